// File: rtl/apb_window_watchdog_mc.sv
// Multi-channel APB watchdog with windowed kick detection.
// One channel instance per watchdog; the top decodes APB, holds the lock and muxes reads.

module apb_window_watchdog_mc_ch #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    input  logic             i_wr_load,
    input  logic             i_wr_ctrl,
    input  logic             i_wr_kick,
    input  logic             i_wr_win,
    input  logic [31:0]      i_wdata,
    output logic [CNT_W-1:0] o_load,
    output logic [CNT_W-1:0] o_value,
    output logic [CNT_W-1:0] o_window,
    output logic [2:0]       o_ctrl,
    output logic [1:0]       o_ris,
    output logic             o_int,
    output logic             o_res
);
    logic [CNT_W-1:0] r_load, r_value, r_window;
    logic [2:0]       r_ctrl;
    logic [1:0]       r_ris;
    logic             r_res;
    logic [CNT_W-1:0] w_wd;
    logic             w_early, w_kick, w_en_on, w_en_off, w_count;

    assign w_wd     = i_wdata[CNT_W-1:0];
    assign w_early  = i_wr_kick & r_ctrl[2] & (r_value > r_window);
    assign w_kick   = i_wr_kick & ~w_early;
    assign w_en_on  = i_wr_ctrl & ~r_ctrl[0] & i_wdata[0];
    assign w_en_off = i_wr_ctrl & r_ctrl[0] & ~i_wdata[0];
    assign w_count  = i_tick & r_ctrl[0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_load   <= '1;
            r_value  <= '1;
            r_window <= '0;
            r_ctrl   <= '0;
            r_ris    <= '0;
            r_res    <= 1'b0;
        end else begin
            if (i_wr_load) r_load   <= w_wd;
            if (i_wr_win)  r_window <= w_wd;
            if (i_wr_ctrl) r_ctrl   <= i_wdata[2:0];
            // Register writes and normal kicks take priority over a same-cycle tick.
            if (i_wr_load) begin
                r_value <= w_wd;
            end else if (w_kick) begin
                r_value  <= r_load;
                r_ris[0] <= 1'b0;
            end else if (w_en_on) begin
                r_value <= r_load;
            end else if (w_en_off) begin
                r_ris[0] <= 1'b0;
            end else if (w_count) begin
                if (r_value != '0) begin
                    r_value <= r_value - CNT_W'(1);
                end else begin
                    r_value <= r_load;
                    if (!r_ris[0])     r_ris[0] <= 1'b1;
                    else if (r_ctrl[1]) r_res   <= 1'b1;
                end
            end
            if (w_early) begin
                r_ris[1] <= 1'b1;
                if (r_ctrl[1]) r_res <= 1'b1;
            end
        end
    end

    assign o_load   = r_load;
    assign o_value  = r_value;
    assign o_window = r_window;
    assign o_ctrl   = r_ctrl;
    assign o_ris    = r_ris;
    // RIS[0] can only be set while INTEN=1 and clears when INTEN drops, so it is already masked.
    assign o_int    = r_ris[0];
    assign o_res    = r_res;
endmodule

module apb_window_watchdog_mc #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic [11:2]       PADDR,
    input  logic              PWRITE,
    input  logic [31:0]       PWDATA,
    input  logic              WDOGCLKEN,
    input  logic [3:0]        ECOREVNUM,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              WDOGINT,
    output logic              WDOGRES,
    output logic [NUM_CH-1:0] WDOGINT_CH,
    output logic [NUM_CH-1:0] WDOGRES_CH
);
    localparam logic [9:0]  A_LOCK = 10'h300;
    localparam logic [9:0]  A_ECO  = 10'h3FA;
    localparam logic [31:0] KEY    = 32'h1ACCE551;
    localparam logic [6:0]  NCH    = 7'(NUM_CH);

    logic                         r_locked;
    logic [6:0]                   w_ch;
    logic [2:0]                   w_off;
    logic                         w_ch_hit, w_map, w_wr, w_cwr;
    logic [31:0]                  w_rdata;
    logic [NUM_CH-1:0][CNT_W-1:0] w_load, w_value, w_window;
    logic [NUM_CH-1:0][2:0]       w_ctrl;
    logic [NUM_CH-1:0][1:0]       w_ris;

    assign w_ch     = PADDR[11:5];
    assign w_off    = PADDR[4:2];
    assign w_ch_hit = (PADDR < A_LOCK) & (w_ch < NCH);
    assign w_map    = (w_ch_hit & (w_off != 3'd7)) | (PADDR == A_LOCK) | (PADDR == A_ECO);
    assign w_wr     = PSEL & PENABLE & PWRITE;
    assign w_cwr    = w_wr & w_ch_hit & ~r_locked;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)                   r_locked <= 1'b0;
        else if (w_wr && PADDR == A_LOCK) r_locked <= (PWDATA != KEY);
    end

    for (genvar gc = 0; gc < NUM_CH; gc++) begin : g_ch
        logic w_sel;
        assign w_sel = w_cwr & (w_ch == 7'(gc));
        apb_window_watchdog_mc_ch #(.CNT_W(CNT_W)) u_ch (
            .i_clk     (PCLK),
            .i_rst_n   (PRESETn),
            .i_tick    (WDOGCLKEN),
            .i_wr_load (w_sel & (w_off == 3'd0)),
            .i_wr_ctrl (w_sel & (w_off == 3'd2)),
            .i_wr_kick (w_sel & (w_off == 3'd3)),
            .i_wr_win  (w_sel & (w_off == 3'd6)),
            .i_wdata   (PWDATA),
            .o_load    (w_load[gc]),
            .o_value   (w_value[gc]),
            .o_window  (w_window[gc]),
            .o_ctrl    (w_ctrl[gc]),
            .o_ris     (w_ris[gc]),
            .o_int     (WDOGINT_CH[gc]),
            .o_res     (WDOGRES_CH[gc])
        );
    end

    always_comb begin
        w_rdata = '0;
        if (PADDR == A_LOCK) begin
            w_rdata = {31'b0, r_locked};
        end else if (PADDR == A_ECO) begin
            w_rdata = {28'b0, ECOREVNUM};
        end else if (w_ch_hit) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_ch == 7'(c)) begin
                    case (w_off)
                        3'd0:    w_rdata = 32'(w_load[c]);
                        3'd1:    w_rdata = 32'(w_value[c]);
                        3'd2:    w_rdata = {29'b0, w_ctrl[c]};
                        3'd4:    w_rdata = {30'b0, w_ris[c]};
                        3'd5:    w_rdata = {31'b0, w_ris[c][0] & w_ctrl[c][0]};
                        3'd6:    w_rdata = 32'(w_window[c]);
                        default: w_rdata = '0;
                    endcase
                end
            end
        end
    end

    assign PRDATA  = (PSEL & ~PWRITE) ? w_rdata : 32'b0;
    assign PREADY  = 1'b1;
    assign PSLVERR = PSEL & PENABLE & ~w_map;
    assign WDOGINT = |WDOGINT_CH;
    assign WDOGRES = |WDOGRES_CH;
endmodule
